// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared bicubic upsample types and constants
package bicubic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam logic [1:0] PHASE_0 = 2'd0;
    localparam logic [1:0] PHASE_1 = 2'd1;
    localparam logic [1:0] PHASE_2 = 2'd2;
    localparam logic [1:0] PHASE_3 = 2'd3;

    localparam int SRC_W_DEF = 960;
    localparam int SRC_H_DEF = 540;

endpackage

// File: rtl/bicubic_credit_cnt.sv
// rtl/bicubic_credit_cnt.sv - in-flight window request counter with stray completion flag
module bicubic_credit_cnt #(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = ($clog2(MAX_OUT + 1) > 0) ? $clog2(MAX_OUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_cpl
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    // Track issued-but-uncompleted requests; a completion with nothing in flight is sticky-flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            err_cpl     <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (outstanding != MAX_CNT) begin
                        outstanding <= outstanding + 1'b1;
                    end
                end
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - 1'b1;
                    end else begin
                        err_cpl <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bicubic_sched_ctrl.sv
// rtl/bicubic_sched_ctrl.sv - bicubic vertical window request scheduler
module bicubic_sched_ctrl
    import bicubic_pkg::*;
#(
    parameter int SRC_W   = SRC_W_DEF,
    parameter int SRC_H   = SRC_H_DEF,
    parameter int MAX_OUT = 8,
    localparam int COL_W  = ($clog2(SRC_W) > 0) ? $clog2(SRC_W) : 1,
    localparam int ROW_W  = ($clog2(SRC_H) > 0) ? $clog2(SRC_H) : 1,
    localparam int CNT_W  = ($clog2(MAX_OUT + 1) > 0) ? $clog2(MAX_OUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             sched_valid,
    input  logic             sched_ready,
    output logic [ROW_W-1:0] sched_row_m1,
    output logic [ROW_W-1:0] sched_row_0,
    output logic [ROW_W-1:0] sched_row_p1,
    output logic [ROW_W-1:0] sched_row_p2,
    output logic [COL_W-1:0] sched_col,
    output logic [1:0]       sched_phase,
    output logic             sched_eol,
    output logic             sched_eof,
    input  logic             cpl,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_cpl
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SRC_H - 1);
    localparam logic [ROW_W:0]   LAST_ROW_X = {1'b0, LAST_ROW};
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    sched_state_t     state;
    logic [COL_W-1:0] x;
    logic [1:0]       p;
    logic [ROW_W-1:0] y;

    logic             run;
    logic             handshake;
    logic             last_col;
    logic             last_phase;
    logic             last_row;
    logic [ROW_W:0]   y_p1;
    logic [ROW_W:0]   y_p2;
    logic [ROW_W-1:0] row_m1;
    logic [ROW_W-1:0] row_p1;
    logic [ROW_W-1:0] row_p2;

    assign run        = (state == ST_RUN);
    assign last_col   = (x == LAST_COL);
    assign last_phase = (p == PHASE_3);
    assign last_row   = (y == LAST_ROW);

    assign sched_valid = run && (outstanding < MAX_CNT);
    assign handshake   = sched_valid && sched_ready;

    // Clamp the 4-tap row window to the source image edges
    always_comb begin
        y_p1   = {1'b0, y} + (ROW_W + 1)'(1);
        y_p2   = {1'b0, y} + (ROW_W + 1)'(2);
        row_m1 = (y == '0) ? '0 : y - 1'b1;
        row_p1 = (y_p1 > LAST_ROW_X) ? LAST_ROW : y_p1[ROW_W-1:0];
        row_p2 = (y_p2 > LAST_ROW_X) ? LAST_ROW : y_p2[ROW_W-1:0];
    end

    // Payload is forced to zero whenever no request can be valid
    assign sched_row_m1 = run ? row_m1 : '0;
    assign sched_row_0  = run ? y      : '0;
    assign sched_row_p1 = run ? row_p1 : '0;
    assign sched_row_p2 = run ? row_p2 : '0;
    assign sched_col    = run ? x      : '0;
    assign sched_phase  = run ? p      : PHASE_0;
    assign sched_eol    = run && last_col;
    assign sched_eof    = run && last_col && last_phase && last_row;

    // Frame sequencing and x/p/y request counters (x innermost, then phase, then row)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            x     <= '0;
            p     <= PHASE_0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        x     <= '0;
                        p     <= PHASE_0;
                        y     <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        if (last_col) begin
                            x <= '0;
                            if (last_phase) begin
                                p <= PHASE_0;
                                y <= last_row ? '0 : y + 1'b1;
                            end else begin
                                p <= p + 2'd1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (sched_eof) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bicubic_credit_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .inc         (handshake),
        .dec         (cpl),
        .outstanding (outstanding),
        .err_cpl     (err_cpl)
    );

endmodule

// File: tb/tb_bicubic_sched_ctrl.sv
// tb/tb_bicubic_sched_ctrl.sv - directed self-checking bench for bicubic_sched_ctrl
module tb_bicubic_sched_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, sched_valid;
    logic       sched_ready = 1'b0;
    logic [1:0] sched_row_m1, sched_row_0, sched_row_p1, sched_row_p2;
    logic [1:0] sched_col, sched_phase;
    logic       sched_eol, sched_eof;
    logic       cpl = 1'b0;
    logic [1:0] outstanding;
    logic       err_cpl;

    logic       h1_start = 1'b0;
    logic       h1_ready = 1'b0;
    logic       h1_cpl = 1'b0;
    logic       h1_busy, h1_done, h1_valid;
    logic [0:0] h1_row_m1, h1_row_0, h1_row_p1, h1_row_p2;
    logic [1:0] h1_col, h1_phase;
    logic       h1_eol, h1_eof;
    logic [1:0] h1_out;
    logic       h1_err;

    int n_cmp = 0;
    int n_err = 0;

    int ex, ep, ey, hs_cnt, eof_at, exp_out;
    logic hist1, hist2;
    logic echo_en, rand_ready;
    logic stall_pend;
    logic [11:0] stall_val, last_payload;

    always #5 clk = ~clk;

    bicubic_sched_ctrl #(.SRC_W(W), .SRC_H(H), .MAX_OUT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sched_valid(sched_valid), .sched_ready(sched_ready),
        .sched_row_m1(sched_row_m1), .sched_row_0(sched_row_0),
        .sched_row_p1(sched_row_p1), .sched_row_p2(sched_row_p2),
        .sched_col(sched_col), .sched_phase(sched_phase),
        .sched_eol(sched_eol), .sched_eof(sched_eof),
        .cpl(cpl), .outstanding(outstanding), .err_cpl(err_cpl)
    );

    bicubic_sched_ctrl #(.SRC_W(W), .SRC_H(1), .MAX_OUT(2)) u_dut_h1 (
        .clk(clk), .rst(rst), .start(h1_start), .busy(h1_busy), .done(h1_done),
        .sched_valid(h1_valid), .sched_ready(h1_ready),
        .sched_row_m1(h1_row_m1), .sched_row_0(h1_row_0),
        .sched_row_p1(h1_row_p1), .sched_row_p2(h1_row_p2),
        .sched_col(h1_col), .sched_phase(h1_phase),
        .sched_eol(h1_eol), .sched_eof(h1_eof),
        .cpl(h1_cpl), .outstanding(h1_out), .err_cpl(h1_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int row_e(int yy, int d);
        int r;
        r = yy + d;
        if (r < 0) r = 0;
        if (r > H - 1) r = H - 1;
        return r;
    endfunction

    function automatic logic [11:0] payload();
        return {sched_col, sched_phase, sched_row_m1, sched_row_0, sched_row_p1, sched_row_p2};
    endfunction

    task automatic model_clear();
        ex = 0; ep = 0; ey = 0; hs_cnt = 0; eof_at = 0;
    endtask

    // One clock: drive ready/cpl at the falling edge, then check against the model
    task automatic tick();
        logic hs;
        int exp_rows;
        @(negedge clk);
        sched_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cpl = echo_en ? hist2 : 1'b0;
        #1;
        chk("outstanding", 32'(outstanding), 32'(exp_out));
        if (stall_pend) begin
            chk("stall_hold", 32'(payload()), 32'(stall_val));
            stall_pend = 1'b0;
        end
        if (sched_valid) begin
            exp_rows = (row_e(ey, -1) << 6) | (row_e(ey, 0) << 4) | (row_e(ey, 1) << 2) | row_e(ey, 2);
            chk("col", 32'(sched_col), 32'(ex));
            chk("phase", 32'(sched_phase), 32'(ep));
            chk("rows", 32'({sched_row_m1, sched_row_0, sched_row_p1, sched_row_p2}), 32'(exp_rows));
            chk("eol", 32'(sched_eol), 32'(ex == W - 1));
            chk("eof", 32'(sched_eof), 32'(ex == W - 1 && ep == 3 && ey == H - 1));
            if (!sched_ready) begin
                stall_pend = 1'b1;
                stall_val  = payload();
            end
        end
        hs = sched_valid & sched_ready;
        if (hs) begin
            hs_cnt++;
            if (hs_cnt == 48) last_payload = payload();
            if (sched_eof) eof_at = hs_cnt;
            ex++;
            if (ex == W) begin
                ex = 0;
                ep++;
                if (ep == 4) begin
                    ep = 0;
                    ey++;
                end
            end
        end
        if (hs && !cpl) exp_out++;
        else if (cpl && !hs && exp_out > 0) exp_out--;
        hist2 = hist1;
        hist1 = hs;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_valid"}, 32'(sched_valid), 0);
        chk({tag, "_payload"}, 32'(payload()), 0);
        chk({tag, "_eol_eof"}, 32'({sched_eol, sched_eof}), 0);
        chk({tag, "_outstanding"}, 32'(outstanding), 0);
        chk({tag, "_err"}, 32'(err_cpl), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; h1_start = 1'b0; cpl = 1'b0; sched_ready = 1'b0;
        @(negedge clk);
        #1;
        check_zero("rst_during");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero("rst_after");
        model_clear();
        exp_out = 0; hist1 = 1'b0; hist2 = 1'b0; stall_pend = 1'b0;
    endtask

    task automatic start_frame();
        model_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int  dcount;
        bit  finished;
        bit  prev_done;
        dcount = 0; finished = 0; prev_done = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            tick();
            if (done) begin
                dcount++;
                chk({tag, "_busy_with_done"}, 32'(busy), 1);
                chk({tag, "_out_at_done"}, 32'(outstanding), 0);
            end else if (prev_done) begin
                chk({tag, "_busy_after_done"}, 32'(busy), 0);
                finished = 1;
            end
            prev_done = done;
        end
        chk({tag, "_done_pulses"}, 32'(dcount), 1);
        chk({tag, "_hs_count"}, 32'(hs_cnt), 48);
        chk({tag, "_eof_at"}, 32'(eof_at), 48);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        echo_en = 1'b1; rand_ready = 1'b0;
        exp_out = 0; hist1 = 1'b0; hist2 = 1'b0; stall_pend = 1'b0;
        stall_val = '0; last_payload = '0;
        model_clear();

        do_reset();

        // Single-row image clamps every tap to row 0
        h1_start = 1'b1;
        @(negedge clk);
        h1_start = 1'b0;
        #1;
        chk("h1_valid", 32'(h1_valid), 1);
        chk("h1_rows", 32'({h1_row_m1, h1_row_0, h1_row_p1, h1_row_p2}), 0);
        chk("h1_col_phase", 32'({h1_col, h1_phase}), 0);
        chk("h1_flags", 32'({h1_busy, h1_done, h1_eol, h1_eof, h1_out, h1_err}), 32'b1000000);

        // Idle without start issues nothing
        tick();
        chk("idle_valid", 32'(sched_valid), 0);
        chk("idle_busy", 32'(busy), 0);

        // Full frame, ready held high, completions echoed two cycles later
        start_frame();
        chk("f1_first_valid", 32'(sched_valid), 1);
        chk("f1_first_payload", 32'(payload()), 32'h006);
        chk("f1_first_busy", 32'(busy), 1);
        run_to_done("f1", 400);
        chk("f1_last_payload", 32'(last_payload), 32'hF6A);

        // Frame with random ready and a start pulse in the middle of RUN
        start_frame();
        for (int g = 0; g < 100 && hs_cnt < 5; g++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rand_ready = 1'b1;
        run_to_done("f2", 2000);
        rand_ready = 1'b0;

        // No completions: credit limit stops issue at two
        echo_en = 1'b0;
        start_frame();
        repeat (10) tick();
        chk("nocpl_hs", 32'(hs_cnt), 2);
        chk("nocpl_valid", 32'(sched_valid), 0);
        chk("nocpl_out", 32'(outstanding), 2);
        echo_en = 1'b1;
        do_reset();

        // Stray completion while idle is flagged and sticks
        @(negedge clk);
        cpl = 1'b1;
        @(negedge clk);
        cpl = 1'b0;
        #1;
        chk("err_set", 32'(err_cpl), 1);
        chk("err_out", 32'(outstanding), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err_cpl), 1);

        // Reset in the middle of a frame, then restart from the top
        start_frame();
        for (int g = 0; g < 200 && hs_cnt < 19; g++) tick();
        chk("r20_reach", 32'(hs_cnt), 19);
        chk("r20_err_sticky", 32'(err_cpl), 1);
        @(negedge clk);
        rst = 1'b1; cpl = 1'b0;
        @(negedge clk);
        #1;
        check_zero("r20_rst");
        rst = 1'b0;
        exp_out = 0; hist1 = 1'b0; hist2 = 1'b0; stall_pend = 1'b0;
        @(negedge clk);
        #1;
        check_zero("r20_idle");
        start_frame();
        chk("r20_restart_valid", 32'(sched_valid), 1);
        chk("r20_restart_payload", 32'(payload()), 32'h006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bicubic_sched_ctrl.md
BICUBIC_SCHED_CTRL -- requirements
Module: bicubic_sched_ctrl

Interface
REQ-001 Parameter SRC_W, default 960: source image width in pixels (columns per pass).
REQ-002 Parameter SRC_H, default 540: source image height in rows.
REQ-003 Parameter MAX_OUT, default 8: maximum issued-but-uncompleted window requests.
REQ-004 Derived widths SHALL be COL_W=$clog2(SRC_W), ROW_W=$clog2(SRC_H), CNT_W=$clog2(MAX_OUT+1), each minimum 1.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  frame start request.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle frame-complete pulse.
REQ-010 sched_valid  out  1  window request valid.
REQ-011 sched_ready  in  1  fetch/datapath accepts request.
REQ-012 sched_row_m1, sched_row_0, sched_row_p1, sched_row_p2  out  ROW_W each  clamped source rows y-1, y, y+1, y+2.
REQ-013 sched_col  out  COL_W  centre column x.
REQ-014 sched_phase  out  2  vertical phase p, selecting one of 4 output rows per source row.
REQ-015 sched_eol, sched_eof  out  1 each  last column of pass; last request of frame.
REQ-016 cpl  in  1  one pulse per output word consumed downstream (rsp handshake).
REQ-017 outstanding  out  CNT_W  current in-flight request count.
REQ-018 err_cpl  out  1  sticky: cpl seen while outstanding==0.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN when start=1; start SHALL be ignored in every other state.
REQ-021 RUN entry SHALL zero x, p, y; first sched_valid possible the cycle after start.
REQ-022 sched_valid SHALL equal (state==RUN) & (outstanding<MAX_OUT); payload driven from registered counters only.
REQ-023 Payload SHALL hold stable while sched_valid=1 and sched_ready=0.
REQ-024 On handshake, x increments; x wraps SRC_W-1->0 and p increments; p wraps 3->0 and y increments.
REQ-025 Issue order SHALL be x innermost, then p, then y: SRC_W*SRC_H*4 requests per frame.
REQ-026 Row outputs SHALL be max(y-1,0), y, min(y+1,SRC_H-1), min(y+2,SRC_H-1); SRC_H=1 gives all zero.
REQ-027 sched_eol = (x==SRC_W-1); sched_eof = sched_eol & (p==3) & (y==SRC_H-1).
REQ-028 Handshake with sched_eof=1 SHALL move RUN->DRAIN.
REQ-029 outstanding: +1 on handshake only, -1 on cpl only, unchanged on both simultaneously, saturates at 0.
REQ-030 cpl with outstanding==0 and no same-cycle handshake SHALL set err_cpl; cleared only by reset.
REQ-031 DRAIN->DONE when outstanding==0; DONE->IDLE unconditionally after one cycle.
REQ-032 done=1 exactly in DONE; busy=1 in RUN, DRAIN, DONE.
REQ-033 sched_ready is don't-care outside RUN; cpl SHALL still be counted in DRAIN.

Reset
REQ-034 rst=1 SHALL force IDLE and zero x, p, y, outstanding, err_cpl on the next edge, including mid-frame.
REQ-035 During and immediately after reset: busy=0, done=0, sched_valid=0, all payload outputs 0.

Structure
REQ-036 Shared package bicubic_pkg SHALL hold state encodings, phase constants (0..3) and SRC_W/SRC_H defaults, also used by the upsample datapath.
REQ-037 One sub-module bicubic_credit_cnt SHALL implement the outstanding counter with err_cpl detection; all else inline.

Verification (SRC_W=4, SRC_H=3, MAX_OUT=2 unless stated)
REQ-038 start, sched_ready=1, cpl echoed 2 cycles after each handshake -> 48 handshakes in x/p/y order, eof on #48, done 1 cycle, busy falls same edge as done.
REQ-039 Rows check: y=0 -> (0,0,1,2); y=2 -> (1,2,2,2); SRC_H=1 -> (0,0,0,0).
REQ-040 cpl tied 0 -> exactly 2 handshakes, then sched_valid=0, outstanding=2 held.
REQ-041 sched_ready random 50% -> payload stable across every stall; handshake plus cpl same cycle -> outstanding unchanged.
REQ-042 cpl with outstanding=0 -> err_cpl=1 sticky; start during RUN -> no counter restart.
REQ-043 rst asserted at request #20 -> next cycle IDLE, all outputs 0; new start -> request #1 payload (0,0,1,2), col 0, phase 0.
